nios_ocimem_access_arbiter: RTL and testbench

- Shares the single-port on-chip debug memory (OCI RAM) between two requesters:
  - the JTAG debug-slave command path, which issues sysclk-domain take-action pulses with decoded jdo fields;
  - the CPU-side Avalon debug_mem_slave.
- Sequences JTAG address-load and auto-incrementing read/write commands.
- Arbitrates fairly against Avalon traffic and returns read data to either side.
- Sits between the debug slave sysclk logic and the OCI RAM instance.

---
 rtl/nios_ocimem_access_arbiter.sv | 177 +++++++++++++++++
 tb/tb_nios_ocimem_access_arbiter.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_ocimem_access_arbiter.sv
// rtl/nios_ocimem_access_arbiter.sv - OCI RAM arbiter between the JTAG debug command path and the Avalon debug_mem_slave
module nios_ocimem_access_arbiter #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              jtag_cmd_valid,
  input  logic              jtag_cmd_set_addr,
  input  logic              jtag_cmd_wr,
  input  logic [ADDR_W-1:0] jtag_cmd_addr,
  input  logic [DATA_W-1:0] jtag_cmd_wdata,
  output logic [DATA_W-1:0] jtag_rdata,
  output logic              jtag_rdata_valid,
  output logic              jtag_busy,
  output logic              jtag_overrun,
  input  logic [ADDR_W-1:0] av_address,
  input  logic              av_read,
  input  logic              av_write,
  input  logic [DATA_W-1:0] av_writedata,
  output logic [DATA_W-1:0] av_readdata,
  output logic              av_waitrequest,
  output logic              ram_en,
  output logic              ram_wren,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    JTAG_RD = 2'd1,
    AV_RD   = 2'd2
  } state_t;

  state_t              state_q, state_d;
  logic                hold_valid_q, hold_valid_d;
  logic                hold_set_q, hold_set_d;
  logic                hold_wr_q, hold_wr_d;
  logic [ADDR_W-1:0]   hold_addr_q, hold_addr_d;
  logic [DATA_W-1:0]   hold_wdata_q, hold_wdata_d;
  logic [ADDR_W-1:0]   ptr_q, ptr_d;
  logic                last_av_q, last_av_d;
  logic [DATA_W-1:0]   jtag_rdata_q, jtag_rdata_d;
  logic [DATA_W-1:0]   av_readdata_q, av_readdata_d;
  logic                overrun_q, overrun_d;

  logic jtag_pend, av_pend, grant_j, grant_a, hold_clear, av_done;

  // Arbitration, RAM strobes and next-state for the holding register, pointer and FSM
  always_comb begin
    state_d       = state_q;
    hold_valid_d  = hold_valid_q;
    hold_set_d    = hold_set_q;
    hold_wr_d     = hold_wr_q;
    hold_addr_d   = hold_addr_q;
    hold_wdata_d  = hold_wdata_q;
    ptr_d         = ptr_q;
    last_av_d     = last_av_q;
    jtag_rdata_d  = jtag_rdata_q;
    av_readdata_d = av_readdata_q;
    overrun_d     = overrun_q;
    ram_en        = 1'b0;
    ram_wren      = 1'b0;
    ram_addr      = '0;
    ram_wdata     = '0;
    jtag_pend     = 1'b0;
    av_pend       = 1'b0;
    grant_j       = 1'b0;
    grant_a       = 1'b0;
    hold_clear    = 1'b0;
    av_done       = 1'b0;

    case (state_q)
      IDLE: begin
        if (hold_valid_q && hold_set_q) begin
          // Pointer load uses no RAM slot but still holds Avalon off for this cycle
          ptr_d      = hold_addr_q;
          hold_clear = 1'b1;
        end else begin
          jtag_pend = hold_valid_q;
          // An Avalon request seen while in reset must not reach the RAM
          av_pend   = (av_read | av_write) & ~reset;
          grant_j   = jtag_pend & (~av_pend | last_av_q);
          grant_a   = av_pend & ~grant_j;
        end

        if (grant_j) begin
          ram_en     = 1'b1;
          ram_wren   = hold_wr_q;
          ram_addr   = ptr_q;
          ram_wdata  = hold_wr_q ? hold_wdata_q : '0;
          ptr_d      = ptr_q + 1'b1;
          hold_clear = 1'b1;
          last_av_d  = 1'b0;
          if (!hold_wr_q) state_d = JTAG_RD;
        end

        if (grant_a) begin
          ram_en    = 1'b1;
          ram_addr  = av_address;
          last_av_d = 1'b1;
          if (av_write) begin
            ram_wren  = 1'b1;
            ram_wdata = av_writedata;
            av_done   = 1'b1;
          end else begin
            state_d = AV_RD;
          end
        end
      end
      JTAG_RD: begin
        jtag_rdata_d = ram_rdata;
        state_d      = IDLE;
      end
      AV_RD: begin
        av_readdata_d = ram_rdata;
        av_done       = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (hold_clear) hold_valid_d = 1'b0;

    // Occupancy is judged on the start-of-cycle value, so a pulse in the emptying cycle is an overrun
    if (jtag_cmd_valid) begin
      if (hold_valid_q) begin
        overrun_d = 1'b1;
      end else begin
        hold_valid_d = 1'b1;
        hold_set_d   = jtag_cmd_set_addr;
        hold_wr_d    = jtag_cmd_wr;
        hold_addr_d  = jtag_cmd_addr;
        hold_wdata_d = jtag_cmd_wdata;
      end
    end
  end

  // State registers with asynchronous clear
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      hold_valid_q  <= 1'b0;
      hold_set_q    <= 1'b0;
      hold_wr_q     <= 1'b0;
      hold_addr_q   <= '0;
      hold_wdata_q  <= '0;
      ptr_q         <= '0;
      last_av_q     <= 1'b1;
      jtag_rdata_q  <= '0;
      av_readdata_q <= '0;
      overrun_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      hold_valid_q  <= hold_valid_d;
      hold_set_q    <= hold_set_d;
      hold_wr_q     <= hold_wr_d;
      hold_addr_q   <= hold_addr_d;
      hold_wdata_q  <= hold_wdata_d;
      ptr_q         <= ptr_d;
      last_av_q     <= last_av_d;
      jtag_rdata_q  <= jtag_rdata_d;
      av_readdata_q <= av_readdata_d;
      overrun_q     <= overrun_d;
    end
  end

  // Read data is forwarded in the capture cycle so both sides see it one clock after the grant
  assign jtag_rdata_valid = (state_q == JTAG_RD);
  assign jtag_rdata       = (state_q == JTAG_RD) ? ram_rdata : jtag_rdata_q;
  assign av_readdata      = (state_q == AV_RD) ? ram_rdata : av_readdata_q;
  assign av_waitrequest   = ~av_done;
  assign jtag_busy        = hold_valid_q;
  assign jtag_overrun     = overrun_q;

endmodule

// File: tb/tb_nios_ocimem_access_arbiter.sv
// tb/tb_nios_ocimem_access_arbiter.sv - self-checking bench for nios_ocimem_access_arbiter
module tb_nios_ocimem_access_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        jtag_cmd_valid, jtag_cmd_set_addr, jtag_cmd_wr;
  logic [7:0]  jtag_cmd_addr;
  logic [31:0] jtag_cmd_wdata;
  logic [31:0] jtag_rdata;
  logic        jtag_rdata_valid, jtag_busy, jtag_overrun;
  logic [7:0]  av_address;
  logic        av_read, av_write;
  logic [31:0] av_writedata, av_readdata;
  logic        av_waitrequest;
  logic        ram_en, ram_wren;
  logic [7:0]  ram_addr;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata;

  int n_chk  = 0;
  int n_fail = 0;

  nios_ocimem_access_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
    .clk(clk), .reset(reset),
    .jtag_cmd_valid(jtag_cmd_valid), .jtag_cmd_set_addr(jtag_cmd_set_addr),
    .jtag_cmd_wr(jtag_cmd_wr), .jtag_cmd_addr(jtag_cmd_addr), .jtag_cmd_wdata(jtag_cmd_wdata),
    .jtag_rdata(jtag_rdata), .jtag_rdata_valid(jtag_rdata_valid),
    .jtag_busy(jtag_busy), .jtag_overrun(jtag_overrun),
    .av_address(av_address), .av_read(av_read), .av_write(av_write),
    .av_writedata(av_writedata), .av_readdata(av_readdata), .av_waitrequest(av_waitrequest),
    .ram_en(ram_en), .ram_wren(ram_wren), .ram_addr(ram_addr),
    .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // Synchronous single-port RAM driven by the DUT
  logic [31:0] mem [256];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_wren) mem[ram_addr] <= ram_wdata;
      else          ram_rdata     <= mem[ram_addr];
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: transaction-level view of the arbiter
  logic [31:0] mmem [256];
  bit          m_hfull, m_hset, m_hwr;
  logic [7:0]  m_haddr, m_ptr, m_rd_addr;
  logic [31:0] m_hdata, m_jrd, m_avrd;
  bit          m_last_av, m_ovr;
  int          m_rd;  // 0 none, 1 JTAG read returning, 2 Avalon read returning

  always @(negedge clk) begin
    bit          e_en, e_wr, e_wait, e_jv, busy0, ovr0, jp, ap, gj, ga;
    logic [7:0]  e_addr;
    logic [31:0] e_wdata, e_jd, e_avd;
    if (reset) begin
      m_hfull = 0; m_hset = 0; m_hwr = 0; m_haddr = 0; m_hdata = 0;
      m_ptr = 0; m_last_av = 1; m_rd = 0; m_jrd = 0; m_avrd = 0; m_ovr = 0;
      chk("rst_ram_en", {31'd0, ram_en}, 0);
      chk("rst_ram_wren", {31'd0, ram_wren}, 0);
      chk("rst_ram_addr", {24'd0, ram_addr}, 0);
      chk("rst_ram_wdata", ram_wdata, 0);
      chk("rst_waitrequest", {31'd0, av_waitrequest}, 1);
      chk("rst_jtag_rdata", jtag_rdata, 0);
      chk("rst_jtag_valid", {31'd0, jtag_rdata_valid}, 0);
      chk("rst_busy", {31'd0, jtag_busy}, 0);
      chk("rst_overrun", {31'd0, jtag_overrun}, 0);
      chk("rst_av_readdata", av_readdata, 0);
    end else begin
      busy0 = m_hfull; ovr0 = m_ovr;
      e_en = 0; e_wr = 0; e_addr = 0; e_wdata = 0; e_wait = 1; e_jv = 0;
      e_jd = m_jrd; e_avd = m_avrd;
      if (m_rd == 1) begin
        e_jv = 1; e_jd = mmem[m_rd_addr]; m_jrd = e_jd; m_rd = 0;
      end else if (m_rd == 2) begin
        e_wait = 0; e_avd = mmem[m_rd_addr]; m_avrd = e_avd; m_rd = 0;
      end else if (m_hfull && m_hset) begin
        m_ptr = m_haddr; m_hfull = 0;
      end else begin
        jp = m_hfull;
        ap = av_read || av_write;
        gj = jp && (!ap || m_last_av);
        ga = ap && !gj;
        if (gj) begin
          e_en = 1; e_wr = m_hwr; e_addr = m_ptr;
          if (m_hwr) begin e_wdata = m_hdata; mmem[m_ptr] = m_hdata; end
          else begin m_rd = 1; m_rd_addr = m_ptr; end
          m_ptr = m_ptr + 8'd1; m_hfull = 0; m_last_av = 0;
        end else if (ga) begin
          e_en = 1; e_addr = av_address; m_last_av = 1;
          if (av_write) begin
            e_wr = 1; e_wdata = av_writedata; e_wait = 0; mmem[av_address] = av_writedata;
          end else begin
            m_rd = 2; m_rd_addr = av_address;
          end
        end
      end
      if (jtag_cmd_valid) begin
        if (busy0) m_ovr = 1;
        else begin
          m_hfull = 1; m_hset = jtag_cmd_set_addr; m_hwr = jtag_cmd_wr;
          m_haddr = jtag_cmd_addr; m_hdata = jtag_cmd_wdata;
        end
      end
      chk("ram_en", {31'd0, ram_en}, {31'd0, e_en});
      chk("ram_wren", {31'd0, ram_wren}, {31'd0, e_wr});
      chk("ram_addr", {24'd0, ram_addr}, {24'd0, e_addr});
      chk("ram_wdata", ram_wdata, e_wdata);
      chk("av_waitrequest", {31'd0, av_waitrequest}, {31'd0, e_wait});
      chk("av_readdata", av_readdata, e_avd);
      chk("jtag_rdata_valid", {31'd0, jtag_rdata_valid}, {31'd0, e_jv});
      chk("jtag_rdata", jtag_rdata, e_jd);
      chk("jtag_busy", {31'd0, jtag_busy}, {31'd0, busy0});
      chk("jtag_overrun", {31'd0, jtag_overrun}, {31'd0, ovr0});
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  task automatic jtag_cmd(input bit set, input bit wr, input logic [7:0] a, input logic [31:0] d);
    int n = 0;
    while (jtag_busy && n < 20) begin step(); n++; end
    if (n >= 20) chk("jtag_busy_timeout", {31'd0, jtag_busy}, 0);
    jtag_cmd_valid = 1; jtag_cmd_set_addr = set; jtag_cmd_wr = wr;
    jtag_cmd_addr = a; jtag_cmd_wdata = d;
    step();
    jtag_cmd_valid = 0; jtag_cmd_set_addr = 0; jtag_cmd_wr = 0;
  endtask

  task automatic wait_jvalid(output int waited);
    waited = 0;
    while (waited < 20) begin
      @(negedge clk);
      waited++;
      if (jtag_rdata_valid) break;
      step();
    end
    if (waited >= 20) chk("jtag_valid_timeout", {31'd0, jtag_rdata_valid}, 1);
  endtask

  task automatic av_rd(input logic [7:0] a, output logic [31:0] d);
    int n = 0;
    av_address = a; av_read = 1; d = 0;
    while (n < 20) begin
      @(negedge clk);
      if (!av_waitrequest) begin d = av_readdata; break; end
      step(); n++;
    end
    if (n >= 20) chk("av_read_timeout", {31'd0, av_waitrequest}, 0);
    step();
    av_read = 0;
  endtask

  initial begin
    logic [31:0] d;
    int w, av_done_cnt, jv_cnt;
    for (int i = 0; i < 256; i++) begin mem[i] = 0; mmem[i] = 0; end
    ram_rdata = 0;
    reset = 1; jtag_cmd_valid = 0; jtag_cmd_set_addr = 0; jtag_cmd_wr = 0;
    jtag_cmd_addr = 0; jtag_cmd_wdata = 0; av_address = 0; av_read = 0; av_write = 0;
    av_writedata = 0;
    idle(3);
    reset = 0;
    idle(2);

    // Test 1: set_addr, write, set_addr, read back; pointer ends at 0x11
    jtag_cmd(1, 0, 8'h10, 0);
    jtag_cmd(0, 1, 0, 32'hDEADBEEF);
    jtag_cmd(1, 0, 8'h10, 0);
    jtag_cmd(0, 0, 0, 0);
    wait_jvalid(w);
    chk("t1_read_latency", w, 2);
    chk("t1_jtag_rdata", jtag_rdata, 32'hDEADBEEF);
    chk("t1_mem10", mem[8'h10], 32'hDEADBEEF);
    idle(2);
    jtag_cmd(0, 1, 0, 32'hCAFE0011);
    idle(3);
    av_rd(8'h11, d);
    chk("t1_ptr_after_read", d, 32'hCAFE0011);

    // Test 2: pointer wrap at 0xFF
    idle(2);
    jtag_cmd(1, 0, 8'hFF, 0);
    jtag_cmd(0, 1, 0, 32'hA5A5A5A5);
    jtag_cmd(0, 1, 0, 32'h5A5A5A5A);
    idle(3);
    chk("t2_memFF", mem[8'hFF], 32'hA5A5A5A5);
    chk("t2_mem00_wrap", mem[8'h00], 32'h5A5A5A5A);

    // Test 5: idle Avalon write completes in its own cycle
    idle(2);
    av_address = 8'h05; av_writedata = 32'h12345678; av_write = 1;
    @(negedge clk);
    chk("t5_write_wait", {31'd0, av_waitrequest}, 0);
    step();
    av_write = 0;
    idle(2);
    chk("t5_mem05", mem[8'h05], 32'h12345678);
    av_rd(8'h05, d);
    chk("t5_readback", d, 32'h12345678);

    // Test 3: Avalon read held while JTAG reads issue back-to-back
    idle(3);
    av_address = 8'h10; av_read = 1;
    av_done_cnt = 0; jv_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      jtag_cmd_valid = !jtag_busy; jtag_cmd_wr = 0; jtag_cmd_set_addr = 0;
      @(negedge clk);
      if (!av_waitrequest) av_done_cnt++;
      if (jtag_rdata_valid) jv_cnt++;
      step();
    end
    av_read = 0; jtag_cmd_valid = 0;
    chk("t3_av_completions", av_done_cnt, 4);
    chk("t3_jtag_completions", jv_cnt, 4);
    idle(4);

    // Test 4: second pulse while first is blocked by an Avalon read -> overrun
    av_address = 8'h05; av_read = 1; jtag_cmd_valid = 1;
    @(negedge clk);
    chk("t4_av_grant_wait", {31'd0, av_waitrequest}, 1);
    step();
    @(negedge clk);
    chk("t4_av_done", {31'd0, av_waitrequest}, 0);
    chk("t4_av_data", av_readdata, 32'h12345678);
    step();
    av_read = 0; jtag_cmd_valid = 0;
    @(negedge clk);
    chk("t4_overrun", {31'd0, jtag_overrun}, 1);
    chk("t4_jtag_grant", {31'd0, ram_en}, 1);
    step();
    @(negedge clk);
    chk("t4_first_completes", {31'd0, jtag_rdata_valid}, 1);
    idle(5);
    chk("t4_overrun_sticky", {31'd0, jtag_overrun}, 1);

    // Test 6: reset during JTAG_RD
    jtag_cmd(1, 0, 8'h10, 0);
    jtag_cmd(0, 0, 0, 0);
    step();
    reset = 1;
    @(negedge clk);
    chk("t6_no_valid", {31'd0, jtag_rdata_valid}, 0);
    chk("t6_wait_in_reset", {31'd0, av_waitrequest}, 1);
    idle(2);
    reset = 0;
    idle(3);
    chk("t6_overrun_cleared", {31'd0, jtag_overrun}, 0);
    chk("t6_rdata_cleared", jtag_rdata, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
